// File: rtl/bit_mem_pkg.sv
// Shared types and sizing helpers for the bit-addressable memory bank.
// Default geometry is a 5-line by 25-bit store.
package bit_mem_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam int DEF_WIDTH = 25;
    localparam int DEF_DEPTH = 5;

    // Bits needed to select one bit within a line (at least one bit).
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Bits needed to select one line of the bank (at least one bit).
    function automatic int adr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bit_memory_bank.sv
// Multi-line bit-addressable store with line loads, registered bit reads and a post-reset clear sweep.
// Optional per-line even parity is enabled by defining BIT_MEM_PARITY_EN.
module bit_memory_bank
    import bit_mem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDXW  = idx_width(DEF_WIDTH),
    parameter int ADRW  = adr_width(DEF_DEPTH)
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [ADRW-1:0]  line_addr,
    input  logic [WIDTH-1:0] line_in,
    input  logic [IDXW-1:0]  index,
    input  logic             val,
    input  logic             write,
    input  logic             read,
    output logic             out,
    output logic             out_valid,
    output logic [WIDTH-1:0] line_out,
    output logic             busy,
`ifdef BIT_MEM_PARITY_EN
    output logic             parity_err,
`endif
    output logic             err
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
`ifdef BIT_MEM_PARITY_EN
    logic             par [0:DEPTH-1];
`endif

    state_t           state;
    logic [ADRW-1:0]  ptr;

    logic             line_ok;
    logic             idx_ok;
    logic [ADRW-1:0]  line_sel;
    logic [IDXW-1:0]  bit_pos;
    logic [WIDTH-1:0] line_wr;
    logic             req_err;

    // Out-of-range selects are steered to entry 0 so no array access ever leaves its bounds;
    // the ok flags keep such requests from having any effect.
    assign line_ok  = int'(line_addr) < DEPTH;
    assign idx_ok   = int'(index) < WIDTH;
    assign line_sel = line_ok ? line_addr : '0;
    assign bit_pos  = idx_ok ? IDXW'(WIDTH - 1 - int'(index)) : '0;
    assign req_err  = (init && !line_ok) || ((write || read) && !(line_ok && idx_ok));

    always_comb begin
        line_wr          = mem[line_sel];
        line_wr[bit_pos] = val;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            busy       <= 1'b1;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            line_out   <= '0;
            err        <= 1'b0;
`ifdef BIT_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    mem[ptr] <= '0;
`ifdef BIT_MEM_PARITY_EN
                    par[ptr] <= 1'b0;
`endif
                    if (ptr == ADRW'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end

                ST_IDLE: begin
                    // Every read-side register sees the contents from before this edge's update.
                    if (line_ok) begin
                        line_out <= mem[line_sel];
                    end

                    if (init && line_ok) begin
                        mem[line_sel] <= line_in;
`ifdef BIT_MEM_PARITY_EN
                        par[line_sel] <= ^line_in;
`endif
                    end else if (write && line_ok && idx_ok) begin
                        mem[line_sel] <= line_wr;
`ifdef BIT_MEM_PARITY_EN
                        par[line_sel] <= ^line_wr;
`endif
                    end

                    if (read && line_ok && idx_ok) begin
                        out       <= mem[line_sel][bit_pos];
                        out_valid <= 1'b1;
`ifdef BIT_MEM_PARITY_EN
                        parity_err <= par[line_sel] != (^mem[line_sel]);
`endif
                    end

                    err <= req_err;
                end

                default: begin
                    state <= ST_CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_memory_bank.sv
// Directed self-checking bench for bit_memory_bank with hand-computed expectations.
// Connects parity_err when BIT_MEM_PARITY_EN is defined.
module tb_bit_memory_bank;

    logic        clk;
    logic        rst;
    logic        init;
    logic [2:0]  line_addr;
    logic [24:0] line_in;
    logic [4:0]  index;
    logic        val;
    logic        write;
    logic        read;
    logic        out;
    logic        out_valid;
    logic [24:0] line_out;
    logic        busy;
    logic        err;
`ifdef BIT_MEM_PARITY_EN
    logic        parity_err;
`endif

    int testCount;
    int failCount;
    int sweepCycles;
    logic sawActivity;

    bit_memory_bank dut (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .line_addr (line_addr),
        .line_in   (line_in),
        .index     (index),
        .val       (val),
        .write     (write),
        .read      (read),
        .out       (out),
        .out_valid (out_valid),
        .line_out  (line_out),
        .busy      (busy),
`ifdef BIT_MEM_PARITY_EN
        .parity_err(parity_err),
`endif
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests, then sample just after the edge that consumes them.
    task automatic applyStimulus(input logic i_init, input logic i_write, input logic i_read,
                                 input logic [2:0] i_line, input logic [4:0] i_index,
                                 input logic i_val, input logic [24:0] i_line_in);
        init      = i_init;
        write     = i_write;
        read      = i_read;
        line_addr = i_line;
        index     = i_index;
        val       = i_val;
        line_in   = i_line_in;
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with busy high, starting from the current sample, bounded at 20 edges.
    task automatic measureSweep(output int n, output logic activity);
        n        = busy ? 1 : 0;
        activity = err | out_valid;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
            activity = activity | err | out_valid;
            if (busy) n++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testCount = 0;
        failCount = 0;
        rst = 1'b0;
        init = 1'b0; write = 1'b0; read = 1'b0;
        line_addr = '0; index = '0; val = 1'b0; line_in = '0;

        // Reset state
        @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_out", out, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_line_out", line_out, 0);
        checkOutput("rst_err", err, 0);

        rst = 1'b1;
        measureSweep(sweepCycles, sawActivity);
        checkOutput("sweep_len", sweepCycles, 5);

        // Every line cleared
        for (int l = 0; l < 5; l++) begin
            applyStimulus(0, 0, 0, 3'(l), 0, 0, 0);
            checkOutput($sformatf("clear_line%0d", l), line_out, 0);
        end

        // Init line 2, read both end bits
        applyStimulus(1, 0, 0, 3'd2, 0, 0, 25'h100_0001);
        applyStimulus(0, 0, 1, 3'd2, 5'd0, 0, 0);
        checkOutput("rd_2_0_out", out, 1);
        checkOutput("rd_2_0_valid", out_valid, 1);
`ifdef BIT_MEM_PARITY_EN
        checkOutput("rd_2_0_parity", parity_err, 0);
`endif
        applyStimulus(0, 0, 1, 3'd2, 5'd24, 0, 0);
        checkOutput("rd_2_24_out", out, 1);
        checkOutput("rd_2_24_valid", out_valid, 1);
        applyStimulus(0, 0, 1, 3'd2, 5'd1, 0, 0);
        checkOutput("rd_2_1_out", out, 0);
        applyStimulus(0, 0, 0, 3'd2, 5'd0, 0, 0);
        checkOutput("idle_valid", out_valid, 0);
        checkOutput("line2_out", line_out, 25'h100_0001);

        // Write and read the same bit in one cycle
        applyStimulus(0, 1, 1, 3'd4, 5'd7, 1, 0);
        checkOutput("rdw_old", out, 0);
        checkOutput("rdw_valid", out_valid, 1);
        applyStimulus(0, 0, 1, 3'd4, 5'd7, 0, 0);
        checkOutput("rdw_new", out, 1);
        applyStimulus(0, 0, 0, 3'd4, 0, 0, 0);
        checkOutput("line4_out", line_out, 25'h002_0000);

        // init beats write on the same line
        applyStimulus(1, 1, 0, 3'd1, 5'd0, 1, 25'h0AB_CDEF);
        applyStimulus(0, 0, 0, 3'd1, 0, 0, 0);
        checkOutput("init_prio", line_out, 25'h0AB_CDEF);

        // Out-of-range requests
        applyStimulus(0, 0, 1, 3'd2, 5'd0, 0, 0);
        checkOutput("pre_oor_out", out, 1);
        applyStimulus(0, 0, 1, 3'd2, 5'd25, 0, 0);
        checkOutput("oor_idx_err", err, 1);
        checkOutput("oor_idx_out", out, 1);
        checkOutput("oor_idx_valid", out_valid, 0);
        applyStimulus(0, 0, 1, 3'd5, 5'd0, 0, 0);
        checkOutput("oor_line_err", err, 1);
        checkOutput("oor_line_out", out, 1);
        checkOutput("oor_line_valid", out_valid, 0);
        applyStimulus(0, 1, 0, 3'd2, 5'd31, 1, 0);
        checkOutput("oor_wr_err", err, 1);
        applyStimulus(0, 0, 0, 3'd2, 0, 0, 0);
        checkOutput("err_clears", err, 0);
        checkOutput("oor_wr_no_effect", line_out, 25'h100_0001);

        // Reset during the sweep restarts it
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        checkOutput("midrst_out", out, 0);
        read      = 1'b1;
        line_addr = 3'd5;
        measureSweep(sweepCycles, sawActivity);
        read      = 1'b0;
        checkOutput("midrst_sweep_len", sweepCycles, 5);
        checkOutput("busy_ignored", sawActivity, 0);
        applyStimulus(0, 0, 0, 3'd2, 0, 0, 0);
        checkOutput("midrst_line2", line_out, 0);
        applyStimulus(0, 0, 0, 3'd1, 0, 0, 0);
        checkOutput("midrst_line1", line_out, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
